// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the ST7735 SPI word writer: FSM state encoding,
// D/C line values and word geometry.
package lcd_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    localparam logic DC_CMD        = 1'b0;
    localparam logic DC_DATA       = 1'b1;
    localparam int   BITS_PER_WORD = 8;
    localparam int   HALF_PERIODS  = 2 * BITS_PER_WORD;

endpackage

// File: rtl/spi_tick_gen.sv
// Divider producing a one-cycle tick every CLK_DIV cycles while enabled;
// the count restarts from zero whenever enable drops.
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = enable_i && (cnt_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (srst_i || !enable_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/lcd_spi_writer.sv
// Serialises one {dc, byte} word per en_write rising edge onto a mode-0
// 4-wire SPI bus (CS, SCL, SDA, D/C) and reports completion with wr_done.
module lcd_spi_writer
    import lcd_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [8:0] data,
    input  logic       en_write,
    output logic       lcd_cs,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_dc,
    output logic       busy,
    output logic       wr_done,
    output logic       wr_ovf
);

    state_t                   state_q;
    logic                     en_q;
    logic [BITS_PER_WORD-1:0] shift_q;
    logic [4:0]               half_cnt_q;
    logic                     cs_q;
    logic                     sclk_q;
    logic                     mosi_q;
    logic                     dc_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     ovf_q;

    logic req;
    logic tick;
    logic tick_en;

    // Only a fresh rising edge is a request, so a level held high by the
    // upstream register after wr_done does not start a second word.
    assign req     = en_write & ~en_q;
    assign tick_en = (state_q != IDLE);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i    (sys_clk),
        .srst_i   (sys_rst),
        .enable_i (tick_en),
        .tick_o   (tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            shift_q    <= '0;
            half_cnt_q <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            dc_q       <= DC_CMD;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            en_q   <= en_write;
            done_q <= 1'b0;
            ovf_q  <= req && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (req) begin
                        shift_q    <= data[7:0];
                        dc_q       <= data[8];
                        mosi_q     <= data[7];
                        cs_q       <= 1'b0;
                        sclk_q     <= 1'b0;
                        half_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    mosi_q <= shift_q[BITS_PER_WORD-1];
                    if (tick) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sclk_q     <= ~sclk_q;
                        half_cnt_q <= half_cnt_q + 5'd1;
                        // Falling edge: the slave sampled on the rise, advance to the next bit.
                        if (sclk_q) begin
                            shift_q <= {shift_q[BITS_PER_WORD-2:0], 1'b0};
                            mosi_q  <= shift_q[BITS_PER_WORD-2];
                        end
                        if (half_cnt_q == 5'(HALF_PERIODS - 1)) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_q    <= 1'b1;
                        sclk_q  <= 1'b0;
                        mosi_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lcd_cs   = cs_q;
    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;
    assign lcd_dc   = dc_q;
    assign busy     = busy_q;
    assign wr_done  = done_q;
    assign wr_ovf   = ovf_q;

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Directed bench: table of single-word transfers with corner-case actions on a
// CLK_DIV=2 instance, plus a 20-word handshake stream on a CLK_DIV=1 instance.
module tb_lcd_spi_writer;
    import lcd_spi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [8:0] data = '0;
    logic       en = 1'b0;
    logic       cs, sclk, mosi, dc, busy, done, ovf;

    logic       rst2 = 1'b1;
    logic [8:0] data2 = '0;
    logic       en2 = 1'b0;
    logic       cs2, sclk2, mosi2, dc2, busy2, done2, ovf2;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_spi_writer #(.CLK_DIV(2)) dut (
        .sys_clk (clk),   .sys_rst (rst),    .data     (data),  .en_write (en),
        .lcd_cs  (cs),    .lcd_sclk (sclk),  .lcd_mosi (mosi),  .lcd_dc   (dc),
        .busy    (busy),  .wr_done (done),   .wr_ovf   (ovf)
    );

    lcd_spi_writer #(.CLK_DIV(1)) dut2 (
        .sys_clk (clk),   .sys_rst (rst2),   .data     (data2), .en_write (en2),
        .lcd_cs  (cs2),   .lcd_sclk (sclk2), .lcd_mosi (mosi2), .lcd_dc   (dc2),
        .busy    (busy2), .wr_done (done2),  .wr_ovf   (ovf2)
    );

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    // act_kind: 0 none, 1 second edge (data 0FF) mid-SHIFT, 2 reset, 3 edge on DONE cycle
    typedef struct {
        logic [8:0] d;
        int         hold;
        int         act_cyc;
        int         act_kind;
        int         e_done_at;
        logic [7:0] e_bits;
        int         e_nrise;
        logic       e_dc;
        int         e_busy;
        int         e_ovf;
        int         e_done_cnt;
    } vec_t;

    typedef struct {
        int         done_at;
        logic [7:0] bits;
        int         nrise;
        logic       dc_low;
        int         dc_bad;
        int         mosi_bad;
        int         busy_cnt;
        int         ovf_cnt;
        int         done_cnt;
        int         post_rst_ok;
    } res_t;

    localparam int WIN = 45;

    // Called at a negedge; cycle n of the loop is T0+n where T0 is the request cycle.
    task automatic xfer(input vec_t v, output res_t r);
        logic p_sclk, p_mosi, dc_seen;
        r.done_at = 0; r.bits = '0; r.nrise = 0; r.dc_low = 1'b0; r.dc_bad = 0;
        r.mosi_bad = 0; r.busy_cnt = 0; r.ovf_cnt = 0; r.done_cnt = 0; r.post_rst_ok = 0;
        p_sclk = 1'b0; p_mosi = 1'b0; dc_seen = 1'b0;
        data = v.d;
        en   = 1'b1;
        for (int n = 1; n <= WIN; n++) begin
            @(negedge clk);
            if (busy) r.busy_cnt++;
            if (ovf) r.ovf_cnt++;
            if (done) begin
                r.done_cnt++;
                if (r.done_at == 0) r.done_at = n;
            end
            if (!cs) begin
                if (sclk && !p_sclk) begin
                    r.bits = {r.bits[6:0], mosi};
                    r.nrise++;
                end
                if (dc_seen && dc != r.dc_low) r.dc_bad++;
                r.dc_low = dc;
                dc_seen  = 1'b1;
            end
            if (sclk && p_sclk && mosi != p_mosi) r.mosi_bad++;
            if (v.act_kind == 2 && n == v.act_cyc + 1)
                r.post_rst_ok = (cs && !sclk && !busy && !done) ? 1 : 0;
            p_sclk = sclk;
            p_mosi = mosi;
            if (n == 1) begin
                data = ~v.d;
                if (v.hold == 0) en = 1'b0;
            end
            if (n == v.act_cyc) begin
                case (v.act_kind)
                    1, 3:    en  = 1'b0;
                    2:       rst = 1'b1;
                    default: ;
                endcase
            end
            if (n == v.act_cyc + 1) begin
                case (v.act_kind)
                    1: begin data = 9'h0FF; en = 1'b1; end
                    3:       en  = 1'b1;
                    2:       rst = 1'b0;
                    default: ;
                endcase
            end
        end
        en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Stream scoreboard for the CLK_DIV=1 instance.
    logic [8:0] exp_q[$];
    logic       p_cs2 = 1'b1, p_sclk2 = 1'b0, dc2_cap = 1'b0;
    logic [7:0] sh2 = '0;
    int nb2 = 0, cyc2 = 0, last_rise2 = 0, last_done2 = 0;
    int done2_cnt = 0, words_seen = 0, period_bad = 0, word_gap_bad = 0;

    always @(negedge clk) begin
        logic [8:0] w;
        cyc2++;
        if (done2) begin
            if (done2_cnt > 0 && cyc2 - last_done2 != 18 * 1 + 3) word_gap_bad++;
            last_done2 = cyc2;
            done2_cnt++;
        end
        if (!cs2 && sclk2 && !p_sclk2) begin
            if (nb2 > 0 && cyc2 - last_rise2 != 2) period_bad++;
            last_rise2 = cyc2;
            sh2        = {sh2[6:0], mosi2};
            dc2_cap    = dc2;
            nb2++;
        end
        if (cs2 && !p_cs2) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_extra_word: got byte 0x%0h, required no word", sh2);
            end else begin
                w = exp_q.pop_front();
                check("stream_byte", int'(sh2), int'(w[7:0]));
                check("stream_dc", int'(dc2_cap), int'(w[8]));
                check("stream_nbits", nb2, 8);
                words_seen++;
                $display("stream word %0d: dc=%0d byte=0x%02h (sent dc=%0d byte=0x%02h)",
                         words_seen, dc2_cap, sh2, w[8], w[7:0]);
            end
            nb2 = 0;
        end
        p_cs2   = cs2;
        p_sclk2 = sclk2;
    end

    vec_t vecs[7];

    initial begin
        res_t r;
        vecs[0] = '{{DC_CMD,  8'h11}, 0,  0, 0, 37, 8'h11, 8, DC_CMD,  37, 0, 1};
        vecs[1] = '{{DC_DATA, 8'hA5}, 0,  0, 0, 37, 8'hA5, 8, DC_DATA, 37, 0, 1};
        vecs[2] = '{{DC_CMD,  8'hC3}, 1,  0, 0, 37, 8'hC3, 8, DC_CMD,  37, 0, 1};
        vecs[3] = '{{DC_DATA, 8'h3C}, 0, 10, 1, 37, 8'h3C, 8, DC_DATA, 37, 1, 1};
        vecs[4] = '{{DC_DATA, 8'hB6}, 0, 21, 2,  0, 8'h16, 5, DC_DATA, 21, 0, 0};
        vecs[5] = '{{DC_CMD,  8'h5A}, 0,  0, 0, 37, 8'h5A, 8, DC_CMD,  37, 0, 1};
        vecs[6] = '{{DC_DATA, 8'h80}, 0, 36, 3, 37, 8'h80, 8, DC_DATA, 37, 1, 1};

        repeat (3) @(negedge clk);
        check("reset_outputs", int'({cs, sclk, mosi, dc, busy, done, ovf}), int'(7'b1000000));
        check("reset_outputs2", int'({cs2, sclk2, mosi2, dc2, busy2, done2, ovf2}), int'(7'b1000000));
        rst  = 1'b0;
        rst2 = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            xfer(vecs[i], r);
            $display("vec %0d: data=0x%03h done_at=%0d bits=0x%02h nrise=%0d dc=%0d busy=%0d ovf=%0d",
                     i, vecs[i].d, r.done_at, r.bits, r.nrise, r.dc_low, r.busy_cnt, r.ovf_cnt);
            check($sformatf("v%0d_done_at", i), r.done_at, vecs[i].e_done_at);
            check($sformatf("v%0d_bits", i), int'(r.bits), int'(vecs[i].e_bits));
            check($sformatf("v%0d_nrise", i), r.nrise, vecs[i].e_nrise);
            check($sformatf("v%0d_dc", i), int'(r.dc_low), int'(vecs[i].e_dc));
            check($sformatf("v%0d_dc_glitch", i), r.dc_bad, 0);
            check($sformatf("v%0d_mosi_unstable", i), r.mosi_bad, 0);
            check($sformatf("v%0d_busy_cycles", i), r.busy_cnt, vecs[i].e_busy);
            check($sformatf("v%0d_ovf_pulses", i), r.ovf_cnt, vecs[i].e_ovf);
            check($sformatf("v%0d_done_pulses", i), r.done_cnt, vecs[i].e_done_cnt);
            if (vecs[i].act_kind == 2)
                check($sformatf("v%0d_post_reset_idle", i), r.post_rst_ok, 1);
        end

        for (int i = 0; i < 20; i++) begin
            logic [8:0] w;
            logic       got;
            w = {1'(i % 2), 8'(i * 37 + 5)};
            exp_q.push_back(w);
            data2 = w;
            en2   = 1'b1;
            got   = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                if (done2) got = 1'b1;
            end
            if (!got) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_timeout word %0d: got no wr_done, required one", i);
            end
            @(negedge clk);
            en2 = 1'b0;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("stream_done_count", done2_cnt, 20);
        check("stream_words_seen", words_seen, 20);
        check("stream_scl_period", period_bad, 0);
        check("stream_word_period", word_gap_bad, 0);
        check("stream_no_ovf", int'(ovf2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
